// File: rtl/if_debug_pkg.sv
// Shared constants for the IF-stage debug sequencer: FSM encodings, command bytes
// and the default halt instruction.
package if_debug_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StReady = 3'd2;
    localparam logic [2:0] StRun   = 3'd3;
    localparam logic [2:0] StStep  = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    localparam logic [7:0] CmdLoad    = 8'h4C;  // 'L'
    localparam logic [7:0] CmdCont    = 8'h43;  // 'C'
    localparam logic [7:0] CmdStep    = 8'h53;  // 'S'
    localparam logic [7:0] CmdNext    = 8'h4E;  // 'N'
    localparam logic [7:0] CmdRestart = 8'h52;  // 'R'

    localparam logic [31:0] HaltWordDefault = 32'hFC00_0000;

    // States in which the instruction memory is read by the pipeline.
    function automatic logic is_exec_state(input logic [2:0] st);
        return (st == StRun) || (st == StStep);
    endfunction

endpackage

// File: rtl/if_load_assembler.sv
// Program-load datapath: address counter, big-endian word assembly, registered byte
// write strobe, and halt-word / end-of-memory detection for the byte being accepted.
module if_load_assembler
    import if_debug_pkg::*;
#(
    parameter int unsigned NB_PC           = 32,
    parameter int unsigned NB_MEM_WIDTH    = 8,
    parameter int unsigned NB_INSTRUCTION  = 32,
    parameter int unsigned MEM_DEPTH_BYTES = 1024,
    parameter logic [NB_INSTRUCTION-1:0] HALT_WORD = NB_INSTRUCTION'(HaltWordDefault)
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_byte_valid,
    input  logic [NB_MEM_WIDTH-1:0]   i_byte,
    output logic                      o_write_enable,
    output logic [NB_MEM_WIDTH-1:0]   o_write_data,
    output logic [NB_PC-1:0]          o_write_addr,
    output logic                      o_halt_match,
    output logic                      o_overflow
);

    logic [NB_PC-1:0]          addr_q;
    logic [NB_INSTRUCTION-1:0] word_q;
    logic [NB_INSTRUCTION-1:0] word_next;

    // Oldest byte shifts toward the MSB, so the first byte of a word ends up on top.
    assign word_next    = {word_q[NB_INSTRUCTION-NB_MEM_WIDTH-1:0], i_byte};
    assign o_halt_match = (addr_q[1:0] == 2'd3) && (word_next == HALT_WORD);
    assign o_overflow   = (addr_q == NB_PC'(MEM_DEPTH_BYTES - 1));

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            addr_q         <= '0;
            word_q         <= '0;
            o_write_enable <= 1'b0;
            o_write_data   <= '0;
            o_write_addr   <= '0;
        end else begin
            o_write_enable <= i_byte_valid;
            if (i_start) begin
                addr_q <= '0;
                word_q <= '0;
            end else if (i_byte_valid) begin
                o_write_data <= i_byte;
                o_write_addr <= addr_q;
                addr_q       <= addr_q + 1'b1;
                word_q       <= word_next;
            end
        end
    end

endmodule

// File: rtl/if_debug_sequencer.sv
// Debug controller for the IF stage: loads instruction memory from a byte stream,
// then runs or single-steps the processor until HALT. Build option: IF_DEBUG_SEQ_STEP_EN.
module if_debug_sequencer
    import if_debug_pkg::*;
#(
    parameter int unsigned NB_PC           = 32,
    parameter int unsigned NB_MEM_WIDTH    = 8,
    parameter int unsigned NB_INSTRUCTION  = 32,
    parameter int unsigned MEM_DEPTH_BYTES = 1024,
    parameter logic [NB_INSTRUCTION-1:0] HALT_WORD = NB_INSTRUCTION'(HaltWordDefault)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NB_MEM_WIDTH-1:0] i_rx_data,
    input  logic                    i_rx_valid,
    input  logic                    i_halt,
    output logic                    o_pc_enable,
    output logic                    o_pc_reset,
    output logic                    o_read_enable,
    output logic                    o_im_enable,
    output logic                    o_write_enable,
    output logic [NB_MEM_WIDTH-1:0] o_write_data,
    output logic [NB_PC-1:0]        o_write_addr,
    output logic                    o_step_done,
    output logic                    o_done,
    output logic                    o_load_error,
    output logic [2:0]              o_state
);

    logic [2:0] state_q, state_d;
    logic       load_error_q, load_error_d;
    logic       pc_enable_q, pc_enable_d;
    logic       pc_reset_q, pc_reset_d;
    logic       read_enable_q, read_enable_d;
    logic       im_enable_q, im_enable_d;
    logic       done_q, done_d;
    logic       load_start, load_byte, step_pulse;
    logic       halt_match, overflow;

    if_load_assembler #(
        .NB_PC           (NB_PC),
        .NB_MEM_WIDTH    (NB_MEM_WIDTH),
        .NB_INSTRUCTION  (NB_INSTRUCTION),
        .MEM_DEPTH_BYTES (MEM_DEPTH_BYTES),
        .HALT_WORD       (HALT_WORD)
    ) u_load_assembler (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_start        (load_start),
        .i_byte_valid   (load_byte),
        .i_byte         (i_rx_data),
        .o_write_enable (o_write_enable),
        .o_write_data   (o_write_data),
        .o_write_addr   (o_write_addr),
        .o_halt_match   (halt_match),
        .o_overflow     (overflow)
    );

    always_comb begin
        state_d      = state_q;
        load_error_d = load_error_q;
        load_start   = 1'b0;
        load_byte    = 1'b0;
        step_pulse   = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_rx_valid && (i_rx_data == CmdLoad)) begin
                    load_start   = 1'b1;
                    load_error_d = 1'b0;
                    state_d      = StLoad;
                end
            end
            StLoad: begin
                if (i_rx_valid) begin
                    load_byte = 1'b1;
                    // A halt word on the last byte is a clean load, not an overflow.
                    if (halt_match) begin
                        state_d = StReady;
                    end else if (overflow) begin
                        load_error_d = 1'b1;
                        state_d      = StReady;
                    end
                end
            end
            StReady: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CmdLoad) begin
                        load_start   = 1'b1;
                        load_error_d = 1'b0;
                        state_d      = StLoad;
                    end else if (i_rx_data == CmdCont) begin
                        state_d = StRun;
`ifdef IF_DEBUG_SEQ_STEP_EN
                    end else if (i_rx_data == CmdStep) begin
                        state_d = StStep;
`endif
                    end
                end
            end
            StRun: begin
                if (i_halt) state_d = StDone;
            end
`ifdef IF_DEBUG_SEQ_STEP_EN
            StStep: begin
                if (i_halt) begin
                    state_d = StDone;
                end else if (i_rx_valid && (i_rx_data == CmdNext)) begin
                    step_pulse = 1'b1;
                end
            end
`endif
            StDone: begin
                if (i_rx_valid && (i_rx_data == CmdRestart)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so every one leaves a flop.
    always_comb begin
        pc_reset_d    = (state_d == StIdle) || (state_d == StLoad) || (state_d == StReady);
        pc_enable_d   = (state_d == StRun) || step_pulse;
        read_enable_d = is_exec_state(state_d);
        im_enable_d   = read_enable_d || load_byte;
        done_d        = (state_d == StDone);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= StIdle;
            load_error_q  <= 1'b0;
            pc_reset_q    <= 1'b1;
            pc_enable_q   <= 1'b0;
            read_enable_q <= 1'b0;
            im_enable_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_error_q  <= load_error_d;
            pc_reset_q    <= pc_reset_d;
            pc_enable_q   <= pc_enable_d;
            read_enable_q <= read_enable_d;
            im_enable_q   <= im_enable_d;
            done_q        <= done_d;
        end
    end

`ifdef IF_DEBUG_SEQ_STEP_EN
    logic step_done_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) step_done_q <= 1'b0;
        else          step_done_q <= step_pulse;
    end

    assign o_step_done = step_done_q;
`else
    assign o_step_done = 1'b0;
`endif

    assign o_state       = state_q;
    assign o_load_error  = load_error_q;
    assign o_pc_reset    = pc_reset_q;
    assign o_pc_enable   = pc_enable_q;
    assign o_read_enable = read_enable_q;
    assign o_im_enable   = im_enable_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_if_debug_sequencer.sv
// Directed bench for if_debug_sequencer: table of per-cycle vectors plus hand-written
// overflow and asynchronous-reset sequences. Step checks follow IF_DEBUG_SEQ_STEP_EN.
module tb_if_debug_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        halt;
    logic        pc_enable, pc_reset, read_enable, im_enable, write_enable;
    logic [7:0]  write_data;
    logic [31:0] write_addr;
    logic        step_done, done, load_error;
    logic [2:0]  state;

    int n_vec;
    int n_err;

    if_debug_sequencer #(
        .MEM_DEPTH_BYTES (16)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .i_halt         (halt),
        .o_pc_enable    (pc_enable),
        .o_pc_reset     (pc_reset),
        .o_read_enable  (read_enable),
        .o_im_enable    (im_enable),
        .o_write_enable (write_enable),
        .o_write_data   (write_data),
        .o_write_addr   (write_addr),
        .o_step_done    (step_done),
        .o_done         (done),
        .o_load_error   (load_error),
        .o_state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected flag order: pc_reset pc_enable read_enable im_enable we step_done done load_error
    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        h;
        logic [2:0]  st;
        logic [7:0]  fl;
        logic [7:0]  wd;
        logic [31:0] wa;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic h,
                                input logic [2:0] st, input logic [7:0] fl,
                                input logic [7:0] wd, input logic [31:0] wa);
        vec_t t;
        t.v = v; t.d = d; t.h = h; t.st = st; t.fl = fl; t.wd = wd; t.wa = wa;
        return t;
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive one cycle of inputs, compare at the following negedge.
    task automatic apply(input vec_t t, input int idx);
        logic [10:0] obs;
        rx_valid = t.v;
        rx_data  = t.d;
        halt     = t.h;
        @(negedge clk);
        rx_valid = 1'b0;
        halt     = 1'b0;
        obs = {state, pc_reset, pc_enable, read_enable, im_enable, write_enable,
               step_done, done, load_error};
        chk($sformatf("vec%0d state/flags", idx), 40'(obs), 40'({t.st, t.fl}));
        if (t.fl[3]) begin
            chk($sformatf("vec%0d write data/addr", idx), {write_data, write_addr},
                {t.wd, t.wa});
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        halt     = 1'b0;

        // Load / reject-unknown / run / halt / restart.
        tbl.push_back(mk(1, 8'h43, 0, 3'd0, 8'b1000_0000, 0, 0));  // 'C' in IDLE ignored
        tbl.push_back(mk(1, 8'h4C, 0, 3'd1, 8'b1000_0000, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 3'd1, 8'b1001_1000, 8'h00, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'd1, 8'b1000_0000, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 3'd1, 8'b1001_1000, 8'h00, 1));
        tbl.push_back(mk(1, 8'h00, 0, 3'd1, 8'b1001_1000, 8'h00, 2));
        tbl.push_back(mk(1, 8'h01, 0, 3'd1, 8'b1001_1000, 8'h01, 3));
        tbl.push_back(mk(1, 8'hFC, 0, 3'd1, 8'b1001_1000, 8'hFC, 4));
        tbl.push_back(mk(1, 8'h00, 0, 3'd1, 8'b1001_1000, 8'h00, 5));
        tbl.push_back(mk(1, 8'h00, 0, 3'd1, 8'b1001_1000, 8'h00, 6));
        tbl.push_back(mk(1, 8'h00, 0, 3'd2, 8'b1001_1000, 8'h00, 7));
        tbl.push_back(mk(1, 8'h7A, 0, 3'd2, 8'b1000_0000, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 3'd2, 8'b1000_0000, 0, 0));
        tbl.push_back(mk(1, 8'h43, 0, 3'd3, 8'b0111_0000, 0, 0));
        for (int i = 0; i < 9; i++) tbl.push_back(mk(0, 8'h00, 0, 3'd3, 8'b0111_0000, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 3'd5, 8'b0000_0010, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3'd5, 8'b0000_0010, 0, 0));
        tbl.push_back(mk(1, 8'h4C, 0, 3'd5, 8'b0000_0010, 0, 0));
        tbl.push_back(mk(1, 8'h52, 0, 3'd0, 8'b1000_0000, 0, 0));
        // Short halt-only program, then step or (stepping disabled) ignored S/N.
        tbl.push_back(mk(1, 8'h4C, 0, 3'd1, 8'b1000_0000, 0, 0));
        tbl.push_back(mk(1, 8'hFC, 0, 3'd1, 8'b1001_1000, 8'hFC, 0));
        tbl.push_back(mk(1, 8'h00, 0, 3'd1, 8'b1001_1000, 8'h00, 1));
        tbl.push_back(mk(1, 8'h00, 0, 3'd1, 8'b1001_1000, 8'h00, 2));
        tbl.push_back(mk(1, 8'h00, 0, 3'd2, 8'b1001_1000, 8'h00, 3));
`ifdef IF_DEBUG_SEQ_STEP_EN
        tbl.push_back(mk(1, 8'h53, 0, 3'd4, 8'b0011_0000, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(1, 8'h4E, 0, 3'd4, 8'b0111_0100, 0, 0));
            tbl.push_back(mk(0, 8'h00, 0, 3'd4, 8'b0011_0000, 0, 0));
        end
        tbl.push_back(mk(1, 8'h4E, 1, 3'd5, 8'b0000_0010, 0, 0));
`else
        tbl.push_back(mk(1, 8'h53, 0, 3'd2, 8'b1000_0000, 0, 0));
        tbl.push_back(mk(1, 8'h4E, 0, 3'd2, 8'b1000_0000, 0, 0));
        tbl.push_back(mk(1, 8'h43, 0, 3'd3, 8'b0111_0000, 0, 0));
        tbl.push_back(mk(1, 8'h4E, 1, 3'd5, 8'b0000_0010, 0, 0));
`endif
        tbl.push_back(mk(1, 8'h52, 0, 3'd0, 8'b1000_0000, 0, 0));

        #23;
        chk("reset state/flags", 40'({state, pc_reset, pc_enable, read_enable, im_enable,
            write_enable, step_done, done, load_error}), 40'({3'd0, 8'b1000_0000}));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) apply(tbl[i], i);

        // Overflow: 16 bytes into a 16-byte memory with no halt word.
        apply(mk(1, 8'h4C, 0, 3'd1, 8'b1000_0000, 0, 0), 100);
        for (int i = 0; i < 16; i++) begin
            apply(mk(1, 8'h11, 0, (i == 15) ? 3'd2 : 3'd1,
                     (i == 15) ? 8'b1001_1001 : 8'b1001_1000, 8'h11, i), 101 + i);
        end
        apply(mk(1, 8'h11, 0, 3'd2, 8'b1000_0001, 0, 0), 117);
        apply(mk(1, 8'h4C, 0, 3'd1, 8'b1000_0000, 0, 0), 118);

        // Asynchronous reset in the middle of a load.
        for (int i = 0; i < 5; i++) begin
            apply(mk(1, 8'(8'h21 + i), 0, 3'd1, 8'b1001_1000, 8'(8'h21 + i), i), 120 + i);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset state/flags", 40'({state, pc_reset, write_enable}),
            40'({3'd0, 1'b1, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply(mk(1, 8'h4C, 0, 3'd1, 8'b1000_0000, 0, 0), 130);
        apply(mk(1, 8'hAA, 0, 3'd1, 8'b1001_1000, 8'hAA, 0), 131);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
